// File: rtl/uart_rx.sv
// Serial receiver: oversampling-free mid-bit sampler, 8N1 framing, one-byte holding register.
// Latency: data/rdy update one cycle after the stop-bit sample (~9.5 bit periods + sync after start edge).
// No backpressure: a byte completing while rdy=1 overwrites data and raises sticky overrun.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rx,
    input  logic [15:0] baud_div,
    input  logic        rd,
    output logic [7:0]  data,
    output logic        rdy,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_vld_q;
    logic                   rxs;
    logic                   rxs_prev;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shreg_q, shreg_d;
    logic                   tick;
    logic                   start_edge;
    logic                   done;

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign tick       = (cnt_q == 16'd0);
    assign start_edge = rxs_prev & ~rxs;
    assign busy       = (state_q != IDLE);

    // rxs_prev stays 0 until the synchronizer has flushed its reset ones, so a
    // line that is already low at reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '1;
            sync_vld_q <= '0;
            rxs_prev   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            rxs_prev   <= sync_vld_q[SYNC_STAGES-1] & rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'hFFFF;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                // Half-period load lands later samples in the middle of each bit.
                if (en && start_edge) begin
                    state_d = START;
                    cnt_d   = {1'b0, baud_div[15:1]};
                end
            end
            START: begin
                if (tick) begin
                    cnt_d = baud_div;
                    if (!rxs) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d          = baud_div;
                    shreg_d[idx_q] = rxs;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d   = baud_div;
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data      <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= done & ~rxs;
            if (done) begin
                data <= shreg_q;
                rdy  <= 1'b1;
                // A read landing with the new byte consumes the old one cleanly.
                if (rd) begin
                    overrun <= 1'b0;
                end else if (rdy) begin
                    overrun <= 1'b1;
                end
            end else if (rd && rdy) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, timing, error, overrun and abort cases at baud_div=9.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rx;
    logic [15:0] baud_div;
    logic        rd;
    logic [7:0]  data;
    logic        rdy;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ferr_cycles = 0;
    int rdy_rises = 0;
    int last_rise_cyc = 0;
    int start_cyc = 0;
    logic rdy_d = 1'b0;

    // Start edge -> rdy: 2 sync + 1 detect + 5 half-bit + 80 data + 10 stop cycles.
    localparam int DONE_OFS = 98;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rx        (rx),
        .baud_div  (baud_div),
        .rd        (rd),
        .data      (data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) ferr_cycles <= ferr_cycles + 1;
        if (rdy && !rdy_d) begin
            rdy_rises     <= rdy_rises + 1;
            last_rise_cyc <= cyc;
        end
        rdy_d <= rdy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_pulse();
        rd = 1'b1;
        tick_n(1);
        rd = 1'b0;
        tick_n(1);
    endtask

    // Drives one 8N1 frame; optional rd strobe and one-cycle en drop at frame cycle offsets.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int rd_at,
                             input int drop_en_at);
        int per;
        int k;
        per = int'(baud_div) + 1;
        start_cyc = cyc;
        for (int i = 0; i < 10 * per; i++) begin
            k = i / per;
            if (k == 0) rx = 1'b0;
            else if (k <= 8) rx = b[k-1];
            else rx = stop;
            rd = (i == rd_at);
            if (i == drop_en_at) check("abort_busy_before", {31'd0, busy}, 32'd1);
            en = (i != drop_en_at);
            tick_n(1);
            if (i == drop_en_at) check("abort_busy_after", {31'd0, busy}, 32'd0);
        end
        rx = 1'b1;
        rd = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        int f0;
        int r0;
        rst_n    = 1'b0;
        en       = 1'b1;
        rx       = 1'b0;
        rd       = 1'b0;
        baud_div = 16'd9;
        tick_n(3);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Line held low across reset release must not start a frame.
        rst_n = 1'b1;
        tick_n(20);
        check("low_line_busy", {31'd0, busy}, 32'd0);
        check("low_line_rdy", {31'd0, rdy}, 32'd0);
        rx = 1'b1;
        tick_n(5);

        f0 = ferr_cycles;
        send_byte(8'hA5, 1'b1, -1, -1);
        tick_n(5);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_rdy", {31'd0, rdy}, 32'd1);
        check("a5_latency", last_rise_cyc - start_cyc, DONE_OFS);
        check("a5_ferr_cycles", ferr_cycles - f0, 32'd0);
        check("a5_overrun", {31'd0, overrun}, 32'd0);
        rd_pulse();
        check("a5_read_rdy", {31'd0, rdy}, 32'd0);
        rd_pulse();
        check("idle_rd_rdy", {31'd0, rdy}, 32'd0);
        check("idle_rd_overrun", {31'd0, overrun}, 32'd0);
        check("idle_rd_data", {24'd0, data}, 32'hA5);

        f0 = ferr_cycles;
        send_byte(8'h3C, 1'b0, -1, -1);
        tick_n(5);
        check("3c_data", {24'd0, data}, 32'h3C);
        check("3c_rdy", {31'd0, rdy}, 32'd1);
        check("3c_ferr_cycles", ferr_cycles - f0, 32'd1);
        rd_pulse();

        f0 = ferr_cycles;
        r0 = rdy_rises;
        rx = 1'b0;
        tick_n(3);
        rx = 1'b1;
        tick_n(3);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        tick_n(15);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_rdy", {31'd0, rdy}, 32'd0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);
        check("glitch_ferr_cycles", ferr_cycles - f0, 32'd0);
        check("glitch_rises", rdy_rises - r0, 32'd0);

        send_byte(8'h11, 1'b1, -1, -1);
        tick_n(3);
        check("ovr_first_overrun", {31'd0, overrun}, 32'd0);
        send_byte(8'h22, 1'b1, -1, -1);
        tick_n(5);
        check("ovr_data", {24'd0, data}, 32'h22);
        check("ovr_rdy", {31'd0, rdy}, 32'd1);
        check("ovr_overrun", {31'd0, overrun}, 32'd1);
        rd_pulse();
        check("ovr_read_rdy", {31'd0, rdy}, 32'd0);
        check("ovr_read_overrun", {31'd0, overrun}, 32'd0);

        send_byte(8'h33, 1'b1, -1, -1);
        tick_n(3);
        send_byte(8'h44, 1'b1, DONE_OFS - 1, -1);
        tick_n(5);
        check("rdcoinc_data", {24'd0, data}, 32'h44);
        check("rdcoinc_rdy", {31'd0, rdy}, 32'd1);
        check("rdcoinc_overrun", {31'd0, overrun}, 32'd0);

        r0 = rdy_rises;
        send_byte(8'hFF, 1'b1, -1, 30);
        tick_n(5);
        check("abort_data_kept", {24'd0, data}, 32'h44);
        check("abort_rdy_kept", {31'd0, rdy}, 32'd1);
        check("abort_overrun", {31'd0, overrun}, 32'd0);
        check("abort_busy_end", {31'd0, busy}, 32'd0);
        check("abort_rises", rdy_rises - r0, 32'd0);
        rd_pulse();

        f0 = ferr_cycles;
        send_byte(8'h5A, 1'b1, -1, -1);
        tick_n(5);
        check("5a_data", {24'd0, data}, 32'h5A);
        check("5a_rdy", {31'd0, rdy}, 32'd1);
        check("5a_latency", last_rise_cyc - start_cyc, DONE_OFS);
        check("5a_ferr_cycles", ferr_cycles - f0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
